// File: rtl/calc_if.sv
// Bundle of the sequencer's switch/key inputs, ALU hookup and display/status outputs.
//   master : board/bench side (drives switches, keys and the ALU result back)
//   slave  : calc_sequencer side
//   sw, sw_func, key_next, key_clr   user inputs
//   alu_a, alu_b, alu_func           registered operands to the ALU
//   alu_result, alu_ovf              combinational ALU response
//   result_q, err_q                  captured result and overflow
//   disp_sel, step, done             display select, LED step code, SHOW flag
interface calc_if #(
  parameter int unsigned WIDTH = 6
) ();
  logic [WIDTH-1:0]   sw;
  logic [1:0]         sw_func;
  logic               key_next;
  logic               key_clr;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [1:0]         alu_func;
  logic [2*WIDTH-1:0] alu_result;
  logic               alu_ovf;
  logic [2*WIDTH-1:0] result_q;
  logic               err_q;
  logic               disp_sel;
  logic [2:0]         step;
  logic               done;

  modport master (
    output sw, sw_func, key_next, key_clr, alu_result, alu_ovf,
    input  alu_a, alu_b, alu_func, result_q, err_q, disp_sel, step, done
  );

  modport slave (
    input  sw, sw_func, key_next, key_clr, alu_result, alu_ovf,
    output alu_a, alu_b, alu_func, result_q, err_q, disp_sel, step, done
  );
endinterface

// File: rtl/calc_sequencer.sv
// Sequencing controller for the ALU/display datapath. One key press per step loads
// operand A, operand B and the function from shared switches, holds the operands on the
// ALU for EXEC_CYCLES, captures result/overflow, then alternates the display between
// operands and result every TOGGLE_CYCLES until the next press.
// Ports:
//   clk  rising-edge system clock
//   rst  synchronous active-high reset (priority over key_clr)
//   bus  calc_if.slave: switches/keys in, ALU operands out, ALU result in,
//        captured result, overflow, display select, step code and done out
module calc_sequencer #(
  parameter int unsigned WIDTH         = 6,
  parameter int unsigned EXEC_CYCLES   = 2,
  parameter int unsigned TOGGLE_CYCLES = 25000000
) (
  input logic   clk,
  input logic   rst,
  calc_if.slave bus
);

  localparam int unsigned ExecW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam int unsigned TogW  = (TOGGLE_CYCLES > 1) ? $clog2(TOGGLE_CYCLES) : 1;
  localparam logic [ExecW-1:0] ExecLast = ExecW'(EXEC_CYCLES - 1);
  localparam logic [TogW-1:0]  TogLast  = TogW'(TOGGLE_CYCLES - 1);

  // Encoding doubles as the LED step code.
  typedef enum logic [2:0] {
    StLoadA = 3'd0,
    StLoadB = 3'd1,
    StLoadF = 3'd2,
    StExec  = 3'd3,
    StShow  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               key_next_q, key_next_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [1:0]         alu_func_q, alu_func_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               err_q, err_d;
  logic               disp_sel_q, disp_sel_d;
  logic               done_q, done_d;
  logic [ExecW-1:0]   exec_cnt_q, exec_cnt_d;
  logic [TogW-1:0]    tog_cnt_q, tog_cnt_d;
  logic               press;

  assign press = bus.key_next & ~key_next_q;

  always_comb begin
    state_d    = state_q;
    key_next_d = bus.key_next;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_func_d = alu_func_q;
    result_d   = result_q;
    err_d      = err_q;
    disp_sel_d = 1'b0;
    exec_cnt_d = exec_cnt_q;
    tog_cnt_d  = tog_cnt_q;

    unique case (state_q)
      StLoadA: begin
        if (press) begin
          alu_a_d = bus.sw;
          state_d = StLoadB;
        end
      end
      StLoadB: begin
        if (press) begin
          alu_b_d = bus.sw;
          state_d = StLoadF;
        end
      end
      StLoadF: begin
        if (press) begin
          alu_func_d = bus.sw_func;
          exec_cnt_d = '0;
          state_d    = StExec;
        end
      end
      StExec: begin
        // Presses here are dropped: key_next_q still tracks the key, so no edge survives.
        if (exec_cnt_q == ExecLast) begin
          result_d   = bus.alu_result;
          err_d      = bus.alu_ovf;
          tog_cnt_d  = '0;
          disp_sel_d = 1'b1;
          state_d    = StShow;
        end else begin
          exec_cnt_d = exec_cnt_q + 1'b1;
        end
      end
      StShow: begin
        if (press) begin
          state_d = StLoadA;
        end else if (tog_cnt_q == TogLast) begin
          tog_cnt_d  = '0;
          disp_sel_d = ~disp_sel_q;
        end else begin
          tog_cnt_d  = tog_cnt_q + 1'b1;
          disp_sel_d = disp_sel_q;
        end
      end
      default: state_d = StLoadA;
    endcase

    // Clear overrides everything above, including a press in the same cycle.
    if (bus.key_clr) begin
      state_d    = StLoadA;
      key_next_d = 1'b0;
      alu_a_d    = '0;
      alu_b_d    = '0;
      alu_func_d = '0;
      result_d   = '0;
      err_d      = 1'b0;
      disp_sel_d = 1'b0;
      exec_cnt_d = '0;
      tog_cnt_d  = '0;
    end

    done_d = (state_d == StShow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoadA;
      key_next_q <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      disp_sel_q <= 1'b0;
      done_q     <= 1'b0;
      exec_cnt_q <= '0;
      tog_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      key_next_q <= key_next_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_func_q <= alu_func_d;
      result_q   <= result_d;
      err_q      <= err_d;
      disp_sel_q <= disp_sel_d;
      done_q     <= done_d;
      exec_cnt_q <= exec_cnt_d;
      tog_cnt_q  <= tog_cnt_d;
    end
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_func = alu_func_q;
  assign bus.result_q = result_q;
  assign bus.err_q    = err_q;
  assign bus.disp_sel = disp_sel_q;
  assign bus.done     = done_q;
  assign bus.step     = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;
  localparam int unsigned W  = 6;
  localparam int unsigned EC = 2;
  localparam int unsigned TC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  calc_if #(.WIDTH(W)) bus ();

  calc_sequencer #(
    .WIDTH        (W),
    .EXEC_CYCLES  (EC),
    .TOGGLE_CYCLES(TC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural ALU: {ovf, result}
  function automatic logic [2*W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] f);
    logic [2*W-1:0] r;
    logic o;
    case (f)
      2'd0: begin r = {{W{1'b0}}, a} + {{W{1'b0}}, b}; o = r[W]; end
      2'd1: begin r = {{W{1'b0}}, a} - {{W{1'b0}}, b}; o = (a < b); end
      2'd2: begin r = {{W{1'b0}}, a} * {{W{1'b0}}, b}; o = |r[2*W-1:W]; end
      default: begin r = {{W{1'b0}}, a ^ b}; o = 1'b0; end
    endcase
    return {o, r};
  endfunction

  assign {bus.alu_ovf, bus.alu_result} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_func);

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase 0..4 = A, B, F, EXEC, SHOW
  int             m_phase = 0;
  int             m_exec = 0;
  int             m_show = 0;
  logic           m_prev = 1'b0;
  logic [W-1:0]   m_a = '0;
  logic [W-1:0]   m_b = '0;
  logic [1:0]     m_f = '0;
  logic [2*W-1:0] m_res = '0;
  logic           m_err = 1'b0;

  task automatic model_edge();
    logic pr;
    logic [2*W:0] alu;
    if (rst || bus.key_clr) begin
      m_phase = 0; m_exec = 0; m_show = 0; m_prev = 1'b0;
      m_a = '0; m_b = '0; m_f = '0; m_res = '0; m_err = 1'b0;
      return;
    end
    pr = bus.key_next && !m_prev;
    m_prev = bus.key_next;
    case (m_phase)
      0: if (pr) begin m_a = bus.sw; m_phase = 1; end
      1: if (pr) begin m_b = bus.sw; m_phase = 2; end
      2: if (pr) begin m_f = bus.sw_func; m_exec = 0; m_phase = 3; end
      3: begin
        m_exec++;
        if (m_exec == EC) begin
          alu = alu_fn(m_a, m_b, m_f);
          m_res = alu[2*W-1:0];
          m_err = alu[2*W];
          m_show = 0;
          m_phase = 4;
        end
      end
      default: if (pr) m_phase = 0; else m_show++;
    endcase
  endtask

  task automatic check(input string name);
    logic [2:0] e_step;
    logic e_done, e_disp;
    e_step = 3'(m_phase);
    e_done = (m_phase == 4);
    e_disp = (m_phase == 4) && (((m_show / TC) % 2) == 0);
    vectors++;
    if (bus.step !== e_step || bus.done !== e_done || bus.disp_sel !== e_disp ||
        bus.alu_a !== m_a || bus.alu_b !== m_b || bus.alu_func !== m_f ||
        bus.result_q !== m_res || bus.err_q !== m_err) begin
      miscompares++;
      $display("FAIL %s @%0t: got step=%0d done=%0b disp=%0b a=%0d b=%0d f=%0d res=%0d err=%0b; %s",
               name, $time, bus.step, bus.done, bus.disp_sel, bus.alu_a, bus.alu_b,
               bus.alu_func, bus.result_q, bus.err_q,
               $sformatf("expected step=%0d done=%0b disp=%0b a=%0d b=%0d f=%0d res=%0d err=%0b",
                         e_step, e_done, e_disp, m_a, m_b, m_f, m_res, m_err));
    end
  endtask

  task automatic chk_val(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check(name);
  endtask

  task automatic press(input logic [W-1:0] s, input logic [1:0] f);
    bus.sw = s;
    bus.sw_func = f;
    bus.key_next = 1'b1;
    cycle("press");
    bus.key_next = 1'b0;
    cycle("release");
  endtask

  typedef struct {
    logic           rst;
    logic           clr;
    logic           key;
    logic [W-1:0]   sw;
    logic [1:0]     fn;
    logic [2:0]     e_step;
    logic           e_done;
    logic           e_disp;
    logic [2*W-1:0] e_res;
  } vec_t;

  vec_t tv[13];

  initial begin
    logic [11:0] disp_pat;
    // rst clr key sw fn -> step done disp result
    tv[0]  = '{1'b1, 1'b0, 1'b0, 6'd0, 2'd0, 3'd0, 1'b0, 1'b0, 12'd0};
    tv[1]  = '{1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 3'd0, 1'b0, 1'b0, 12'd0};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 6'd5, 2'd0, 3'd1, 1'b0, 1'b0, 12'd0};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 6'd5, 2'd0, 3'd1, 1'b0, 1'b0, 12'd0};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 6'd3, 2'd0, 3'd1, 1'b0, 1'b0, 12'd0};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 6'd3, 2'd0, 3'd2, 1'b0, 1'b0, 12'd0};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 3'd2, 1'b0, 1'b0, 12'd0};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 6'd0, 2'd0, 3'd3, 1'b0, 1'b0, 12'd0};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 3'd3, 1'b0, 1'b0, 12'd0};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 3'd4, 1'b1, 1'b1, 12'd8};
    tv[10] = '{1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 3'd4, 1'b1, 1'b1, 12'd8};
    tv[11] = '{1'b0, 1'b0, 1'b1, 6'd0, 2'd0, 3'd0, 1'b0, 1'b0, 12'd8};
    tv[12] = '{1'b0, 1'b1, 1'b0, 6'd0, 2'd0, 3'd0, 1'b0, 1'b0, 12'd0};

    bus.sw = '0;
    bus.sw_func = '0;
    bus.key_next = 1'b0;
    bus.key_clr = 1'b0;

    foreach (tv[i]) begin
      rst = tv[i].rst;
      bus.key_clr = tv[i].clr;
      bus.key_next = tv[i].key;
      bus.sw = tv[i].sw;
      bus.sw_func = tv[i].fn;
      cycle("table_model");
      vectors++;
      if (bus.step !== tv[i].e_step || bus.done !== tv[i].e_done ||
          bus.disp_sel !== tv[i].e_disp || bus.result_q !== tv[i].e_res) begin
        miscompares++;
        $display("FAIL table[%0d]: got step=%0d done=%0b disp=%0b res=%0d expected %0d %0b %0b %0d",
                 i, bus.step, bus.done, bus.disp_sel, bus.result_q, tv[i].e_step,
                 tv[i].e_done, tv[i].e_disp, tv[i].e_res);
      end
    end
    rst = 1'b0;
    bus.key_clr = 1'b0;
    bus.key_next = 1'b0;
    cycle("idle");

    // Display alternation in SHOW: 5-3 = 2
    press(6'd5, 2'd0);
    press(6'd3, 2'd0);
    press(6'd0, 2'd1);
    disp_pat = 12'b1111_0000_1111;
    for (int k = 0; k < 12; k++) begin
      cycle("show_hold");
      chk_val("disp_seq", int'(bus.disp_sel), int'(disp_pat[11-k]));
    end
    bus.key_next = 1'b1;
    cycle("show_exit");
    chk_val("exit_step", int'(bus.step), 0);
    chk_val("exit_disp", int'(bus.disp_sel), 0);
    chk_val("exit_alu_a", int'(bus.alu_a), 5);
    chk_val("exit_result", int'(bus.result_q), 2);
    bus.key_next = 1'b0;
    cycle("idle");

    // Held key gives a single advance
    bus.sw = 6'd7;
    bus.key_next = 1'b1;
    repeat (10) cycle("held_key");
    bus.key_next = 1'b0;
    cycle("held_release");
    chk_val("held_step", int'(bus.step), 1);
    chk_val("held_alu_a", int'(bus.alu_a), 7);

    // Press inside EXEC is dropped
    press(6'd3, 2'd0);
    bus.sw_func = 2'd3;
    bus.key_next = 1'b1;
    cycle("exec_enter");
    bus.key_next = 1'b0;
    cycle("exec_1");
    bus.key_next = 1'b1;
    cycle("exec_press");
    chk_val("exec_reach_show", int'(bus.step), 4);
    bus.key_next = 1'b0;
    repeat (3) cycle("exec_after");
    chk_val("exec_stay_show", int'(bus.step), 4);
    chk_val("exec_result", int'(bus.result_q), 4);

    // Overflow, then clear beating a simultaneous press
    press(6'd0, 2'd0);
    press(6'd31, 2'd0);
    press(6'd31, 2'd0);
    press(6'd0, 2'd2);
    cycle("ovf_show");
    chk_val("ovf_err", int'(bus.err_q), 1);
    chk_val("ovf_result", int'(bus.result_q), 961);
    bus.key_clr = 1'b1;
    bus.key_next = 1'b1;
    cycle("clr_press");
    chk_val("clr_step", int'(bus.step), 0);
    chk_val("clr_err", int'(bus.err_q), 0);
    bus.key_clr = 1'b0;
    bus.key_next = 1'b0;
    cycle("idle");

    // Reset on the capture cycle of EXEC
    press(6'd5, 2'd0);
    press(6'd3, 2'd0);
    bus.sw_func = 2'd0;
    bus.key_next = 1'b1;
    cycle("rst_exec0");
    bus.key_next = 1'b0;
    cycle("rst_exec1");
    rst = 1'b1;
    cycle("rst_in_exec");
    chk_val("rst_step", int'(bus.step), 0);
    chk_val("rst_result", int'(bus.result_q), 0);
    rst = 1'b0;
    cycle("idle");

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bus.key_next = ($urandom_range(0, 2) == 0);
      bus.key_clr = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 127) == 0);
      bus.sw = W'($urandom);
      bus.sw_func = 2'($urandom);
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
